// File: rtl/pwm_contador_pkg.sv
// Shared types and defaults for the pwm_contador block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding (2'd3 is unused and is decoded as IDLE by
// the FSM), the default widths and a small state-decode helper.
package pwm_contador_pkg;

  // Default width of count, modulus and duty; must match contador_N.
  localparam int DEF_W      = 8;
  // Default width of the completed-period counter.
  localparam int DEF_PCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // True in the states that react to period boundaries. Any encoding other
  // than SYNC/RUN (including the unused 2'd3) behaves as IDLE.
  function automatic logic st_active(input state_t s);
    return (s == ST_SYNC) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/pwm_wrap_detect.sv
// Period-boundary detector: flags the cycle where contador_N's count restarts at 0.
// Latency: combinational from q_in (q_prev adds one cycle of history).
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   en            run enable; no boundary is reported while low
//   q_in, n_in    count and modulus currently applied to contador_N
//   boundary      1 on every cycle that starts a new period
module pwm_wrap_detect
  import pwm_contador_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] n_in,
  output logic         boundary
);

  logic [W-1:0] q_prev;

  // q_prev follows q_in unconditionally so history is valid as soon as en rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_prev <= '0;
    end else begin
      q_prev <= q_in;
    end
  end

  // A period starts when the count lands on 0 coming from a non-zero value.
  // This also covers an external contador_N reset mid-period. With a modulus
  // of 0 or 1 the count never leaves 0, so every cycle is a period start.
  always_comb begin
    boundary = en && (q_in == '0) && ((q_prev != '0) || (n_in <= W'(1)));
  end

endmodule

// File: rtl/pwm_contador.sv
// PWM generator driven by contador_N's running count, with double-buffered duty updates.
// Latency: pwm_out and period_tick are registered, one cycle after the q_in they reflect.
// Backpressure: duty_ready drops while a duty value is pending; it rises the cycle after a boundary applies it.
//
// Optional feature macro: PWM_CONTADOR_PCNT_EN adds the PCNT_W parameter,
// the period_cnt port and its register. Without it nothing else changes.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   en                     run enable; low forces IDLE and pwm_out=0
//   q_in, n_in             count and modulus of contador_N
//   duty_in/duty_valid     requested high-time (in counts) and its valid
//   duty_ready             pending buffer empty; transfer on valid && ready
//   pwm_out                registered PWM output
//   period_tick            one-cycle pulse at each period start seen in SYNC/RUN
//   busy                   state is not IDLE
//   period_cnt             periods completed in RUN (optional)
module pwm_contador
  import pwm_contador_pkg::*;
#(
  parameter int W = DEF_W
`ifdef PWM_CONTADOR_PCNT_EN
  ,
  parameter int PCNT_W = DEF_PCNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      q_in,
  input  logic [W-1:0]      n_in,
  input  logic [W-1:0]      duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_tick,
  output logic              busy
`ifdef PWM_CONTADOR_PCNT_EN
  ,
  output logic [PCNT_W-1:0] period_cnt
`endif
);

  state_t       state;
  state_t       state_nxt;
  logic         boundary;
  logic         period_start;
  logic         accept;
  logic         load;
  logic [W-1:0] pending;
  logic         pending_full;
  logic [W-1:0] active_duty;
  logic [W-1:0] eff_duty;
  logic         pwm_nxt;

  pwm_wrap_detect #(
    .W (W)
  ) u_wrap (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .q_in     (q_in),
    .n_in     (n_in),
    .boundary (boundary)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_SYNC;
      ST_SYNC: if (boundary) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = en ? ST_SYNC : ST_IDLE;
    endcase
    // Dropping en wins over every transition.
    if (!en) state_nxt = ST_IDLE;
  end

  assign busy = st_active(state);

  // ---------------------------------------------------------------------------
  // Duty double buffer
  // ---------------------------------------------------------------------------
  // A boundary seen in SYNC or RUN starts a period: it ticks and applies the
  // pending duty. In SYNC that same boundary is also the first RUN period, so
  // the comparator is already live on it and pwm_out lines up with the tick.
  assign period_start = boundary && st_active(state);
  assign duty_ready   = !pending_full;
  assign accept       = duty_valid && !pending_full;
  assign load         = period_start && pending_full;

  // accept needs an empty buffer and load needs a full one, so the two never
  // collide. A value accepted on a boundary with an empty buffer therefore
  // waits for the following boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      pending_full <= 1'b0;
      active_duty  <= '0;
    end else begin
      if (load) begin
        active_duty  <= pending;
        pending_full <= 1'b0;
      end
      if (accept) begin
        pending      <= duty_in;
        pending_full <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comparator
  // ---------------------------------------------------------------------------
  // The duty being loaded this cycle must already govern the Q==0 sample,
  // otherwise the first cycle of every updated period would use stale duty.
  // Duty >= modulus saturates naturally because q_in never reaches n_in.
  always_comb begin
    eff_duty = load ? pending : active_duty;
    pwm_nxt  = 1'b0;
    if (en && ((state == ST_RUN) || period_start)) begin
      pwm_nxt = (q_in < eff_duty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= pwm_nxt;
      period_tick <= period_start;
    end
  end

`ifdef PWM_CONTADOR_PCNT_EN
  // Only RUN boundaries close a period; the SYNC boundary merely opens the first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
    end else if (boundary && (state == ST_RUN)) begin
      period_cnt <= period_cnt + PCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pwm_contador.sv
// Self-checking bench for pwm_contador, driven by a behavioural contador_N.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: duty pushes hold duty_valid until duty_ready was seen high.
module tb_pwm_contador;

  localparam int W      = 8;
  localparam int PCNT_W = 16;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         en         = 1'b0;
  logic         duty_valid = 1'b0;
  logic         cnt_clr    = 1'b0;
  logic [W-1:0] q_in       = '0;
  logic [W-1:0] n_in       = 8'd5;
  logic [W-1:0] duty_in    = '0;
  logic         duty_ready;
  logic         pwm_out;
  logic         period_tick;
  logic         busy;
`ifdef PWM_CONTADOR_PCNT_EN
  logic [PCNT_W-1:0] period_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  pwm_contador #(
    .W (W)
`ifdef PWM_CONTADOR_PCNT_EN
    ,
    .PCNT_W (PCNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .q_in        (q_in),
    .n_in        (n_in),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .busy        (busy)
`ifdef PWM_CONTADOR_PCNT_EN
    ,
    .period_cnt  (period_cnt)
`endif
  );

  always #10 clk = ~clk;

  // contador_N: counts 0..N-1, synchronous clear, stuck at 0 for N<=1.
  always @(posedge clk) begin
    if (cnt_clr || (n_in <= 8'd1) || (q_in >= n_in - 8'd1)) q_in <= '0;
    else q_in <= q_in + 8'd1;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: period starts, a one-deep duty mailbox and a mode number
  // (0 stopped, 1 waiting for a period start, 2 running).
  // ---------------------------------------------------------------------------
  int m_mode = 0, m_last_q = 0, m_active = 0, m_pend = 0, m_duty_now = 0;
  bit m_full = 0, m_bnd = 0, m_start = 0, m_accept = 0;
  bit e_pwm = 0, e_tick = 0;
`ifdef PWM_CONTADOR_PCNT_EN
  int m_pcnt = 0;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_last_q = 0; m_active = 0; m_pend = 0; m_full = 0;
      e_pwm = 0; e_tick = 0;
`ifdef PWM_CONTADOR_PCNT_EN
      m_pcnt = 0;
`endif
    end else begin
      m_bnd      = en && (q_in == 0) && ((m_last_q != 0) || (n_in <= 1));
      m_last_q   = q_in;
      m_start    = m_bnd && (m_mode != 0);
      m_duty_now = (m_start && m_full) ? m_pend : m_active;
      e_pwm      = en && ((m_mode == 2) || m_start) && (int'(q_in) < m_duty_now);
      e_tick     = m_start;
`ifdef PWM_CONTADOR_PCNT_EN
      if ((m_mode == 2) && m_bnd) m_pcnt = (m_pcnt + 1) % (1 << PCNT_W);
`endif
      m_accept = duty_valid && !m_full;
      if (m_start && m_full) begin m_active = m_pend; m_full = 0; end
      if (m_accept) begin m_pend = duty_in; m_full = 1; end
      if (!en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if ((m_mode == 1) && m_bnd) m_mode = 2;
    end
    #1;
    chk("pwm_out", pwm_out, e_pwm);
    chk("period_tick", period_tick, e_tick);
    chk("busy", busy, m_mode != 0);
    chk("duty_ready", duty_ready, !m_full);
`ifdef PWM_CONTADOR_PCNT_EN
    chk("period_cnt", int'(period_cnt), m_pcnt);
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. "Sample point" = 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  // Call at a falling edge; returns at the falling edge after the transfer.
  task automatic push(input int d);
    bit r, done;
    done = 0;
    duty_valid = 1'b1;
    duty_in    = W'(d);
    for (int i = 0; i < 200; i++) begin
      r = duty_ready;
      @(posedge clk);
      if (r) begin done = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    duty_valid = 1'b0;
    chk("push_accepted", done, 1);
  endtask

  // Returns at the first sample point showing period_tick=1.
  task automatic tick_wait(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (period_tick) begin found = 1; break; end
    end
    chk("tick_wait", found, 1);
  endtask

  // Returns at the falling edge before the rising edge that sees q_in==v.
  task automatic at_q(input int v);
    bit found;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q_in == W'(v)) begin found = 1; break; end
    end
    chk("at_q", found, 1);
  endtask

  // Call at a sample point; counts that sample and the next len-1.
  task automatic count_win(input int len, output int npwm, output int ntick);
    npwm = 0; ntick = 0;
    for (int i = 0; i < len; i++) begin
      npwm  += int'(pwm_out);
      ntick += int'(period_tick);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
    $fatal(1, "watchdog");
  end

  int np, nt;
  int ext_duty [3] = '{0, 5, 255};
  int ext_high [3] = '{0, 10, 10};

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", duty_ready, 1);
    rst = 1'b1;

    // 1: duty 2 of 5, pushed while idle; first tick waits for Q to wrap.
    n_in = 8'd5;
    @(negedge clk);
    push(2);
    chk("s1_ready_held", duty_ready, 0);
    at_q(2);
    en = 1'b1;
    tick_wait(20);
    chk("s1_first_tick_q", q_in, 1);
    count_win(10, np, nt);
    chk("s1_pwm_high", np, 4);
    chk("s1_ticks", nt, 2);

    // 2: duty 3 pushed mid-period; applies from the next Q==0.
    at_q(2);
    push(3);
    chk("s2_ready_low", duty_ready, 0);
    tick_wait(20);
    chk("s2_ready_back", duty_ready, 1);
    count_win(5, np, nt);
    chk("s2_pwm_high", np, 3);

    // 3: extremes.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push(ext_duty[k]);
      tick_wait(20);
      count_win(10, np, nt);
      chk("s3_pwm_extreme", np, ext_high[k]);
    end
    @(negedge clk);
    n_in = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    count_win(10, np, nt);
    chk("s3_n1_ticks", nt, 10);
    chk("s3_n1_pwm", np, 10);

    // 4: counter cleared mid-period, then modulus widened.
    @(negedge clk);
    n_in = 8'd20;
    push(7);
    tick_wait(60);
    at_q(12);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk("s4_no_tick_yet", period_tick, 0);
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    chk("s4_tick_after_clr", period_tick, 1);
    @(negedge clk);
    n_in = 8'd100;
    tick_wait(150);
    count_win(100, np, nt);
    chk("s4_n100_pwm", np, 7);
    chk("s4_n100_ticks", nt, 1);

    // 5: en dropped at Q=3, then re-enabled.
    @(negedge clk);
    n_in = 8'd5;
    tick_wait(200);
    at_q(3);
    en = 1'b0;
    @(posedge clk); #1;
    chk("s5_pwm_off", pwm_out, 0);
    chk("s5_busy_off", busy, 0);
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    chk("s5_busy_on", busy, 1);
    tick_wait(20);
    chk("s5_tick_q", q_in, 1);

    // Asynchronous reset mid-RUN (duty 7 >= N keeps pwm high beforehand).
    repeat (2) @(posedge clk);
    @(negedge clk);
    #5 rst = 1'b0;
    #2;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_tick", period_tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", duty_ready, 1);
    @(negedge clk);
    rst = 1'b1;

`ifdef PWM_CONTADOR_PCNT_EN
    // 6: period counter and its wrap.
    n_in = 8'd5;
    en   = 1'b1;
    @(negedge clk);
    push(2);
    tick_wait(20);
    chk("s6_cnt_first", int'(period_cnt), 0);
    for (int k = 0; k < 10; k++) tick_wait(20);
    chk("s6_cnt_10", int'(period_cnt), 10);
    @(negedge clk);
    n_in = 8'd1;
    begin
      bit wrapped;
      wrapped = 0;
      for (int i = 0; i < 70000; i++) begin
        @(posedge clk); #1;
        if (period_cnt == '0) begin wrapped = 1; break; end
      end
      chk("s6_wrap", wrapped, 1);
    end
`endif

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en         = ($urandom_range(0, 19) != 0);
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in    = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 14));
      cnt_clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) n_in = W'($urandom_range(0, 12));
    end
    @(negedge clk);
    duty_valid = 1'b0;
    cnt_clr    = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
